// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
// Input front end for the irrigation controller. Five raw field inputs
// (bit0 Us, bit1 Bs, bit2 Vs, bit3 Adub, bit4 T1) are synchronised into the
// Clk domain. Each one is debounced on a slow sample tick. The block delivers
// clean levels and one-cycle Rise/Fall pulses. Pulses are held off until the
// initial qualification window has elapsed, which is signalled by Ready.
// Every output comes straight from a flop; there is no combinational path
// from Raw to any output.
module sensor_input_conditioner #(
    parameter int TICK_DIV = 50000,
    parameter int DB_COUNT = 10
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] Raw,
    output logic [4:0] Clean,
    output logic [4:0] Rise,
    output logic [4:0] Fall,
    output logic       Ready
);

    localparam int NCH = 5;
    // A one-cycle tick period still needs a 1-bit prescaler.
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW  = $clog2(DB_COUNT + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DB_COUNT - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DB_COUNT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    logic [NCH-1:0] sync1_reg;
    logic [NCH-1:0] sync2_reg;
    logic [PW-1:0]  presc_reg;
    logic [PW-1:0]  presc_next;
    logic           tick;
    logic [CW-1:0]  ready_cnt_reg;
    logic [CW-1:0]  ready_cnt_next;
    logic           ready_reg;
    logic           ready_next;

    // Two-flop synchroniser; sync2_reg is the only copy the debouncers see.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= Raw;
            sync2_reg <= sync1_reg;
        end
    end

    // The prescaler free-runs from 0 to TICK_DIV-1. Tick is high in its last cycle.
    always_comb begin
        presc_next = presc_reg + PRESC_ONE;
        if (presc_reg == PRESC_LAST) begin
            presc_next = '0;
        end
    end

    assign tick = (presc_reg == PRESC_LAST);

    // Prescaler state register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // The qualification counter saturates at DB_COUNT. Ready rises on the same edge.
    always_comb begin
        ready_cnt_next = ready_cnt_reg;
        ready_next     = ready_reg;
        if (tick && (ready_cnt_reg != CNT_FULL)) begin
            ready_cnt_next = ready_cnt_reg + CNT_ONE;
            if (ready_cnt_reg == CNT_LAST) begin
                ready_next = 1'b1;
            end
        end
    end

    // Qualification state register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ready_cnt_reg <= '0;
            ready_reg     <= 1'b0;
        end else begin
            ready_cnt_reg <= ready_cnt_next;
            ready_reg     <= ready_next;
        end
    end

    assign Ready = ready_reg;

    // The five channels are identical and fully independent.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          clean_reg;
            logic          clean_next;
            logic          rise_reg;
            logic          rise_next;
            logic          fall_reg;
            logic          fall_next;

            // On a tick, count consecutive disagreeing samples. Any agreeing
            // sample discards the count. The DB_COUNT-th disagreement flips the level.
            always_comb begin
                cnt_next   = cnt_reg;
                clean_next = clean_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                if (tick) begin
                    if (sync2_reg[gi] == clean_reg) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        clean_next = ~clean_reg;
                        // Pulses use the Ready value from before this edge.
                        // Levels accepted during qualification therefore stay silent.
                        rise_next  = ready_reg & ~clean_reg;
                        fall_next  = ready_reg &  clean_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            // Per-channel state and edge-pulse registers.
            always_ff @(posedge Clk) begin
                if (!Rst) begin
                    cnt_reg   <= '0;
                    clean_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    clean_reg <= clean_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            assign Clean[gi] = clean_reg;
            assign Rise[gi]  = rise_reg;
            assign Fall[gi]  = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// tb_sensor_input_conditioner
// Directed scenarios followed by a randomised phase. Each cycle the outputs
// are compared against a reference model. The model keeps a log of the raw
// value applied at each edge since reset. It counts consecutive disagreeing
// tick samples per channel.
module tb_sensor_input_conditioner;

    localparam int TICK_DIV = 4;
    localparam int DB_COUNT = 3;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [4:0] Raw = 5'd0;
    logic [4:0] Clean;
    logic [4:0] Rise;
    logic [4:0] Fall;
    logic       Ready;

    sensor_input_conditioner #(
        .TICK_DIV(TICK_DIV),
        .DB_COUNT(DB_COUNT)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Raw  (Raw),
        .Clean(Clean),
        .Rise (Rise),
        .Fall (Fall),
        .Ready(Ready)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         k = 0;              // edges since reset release
    logic [4:0] raw_log[$];         // raw applied at edge 1..k
    int         m_cnt[5];
    logic [4:0] m_clean = '0;
    logic [4:0] m_rise  = '0;
    logic [4:0] m_fall  = '0;
    logic       m_ready = 1'b0;

    // Pulse bookkeeping for the directed scenarios
    int         rise_seen;
    int         fall_seen;
    logic [4:0] rise_val;
    logic [4:0] fall_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, and compare every output.
    task automatic step(input logic [4:0] r, input logic rn);
        logic [4:0] sb;
        logic [4:0] nv;
        Raw = r;
        Rst = rn;
        @(posedge Clk);
        if (!rn) begin
            k = 0;
            raw_log.delete();
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_ready = 1'b0;
        end else begin
            k++;
            raw_log.push_back(r);
            // The debouncer sees the raw value applied two edges earlier.
            sb = (raw_log.size() >= 3) ? raw_log[raw_log.size() - 3] : 5'd0;
            m_rise = '0;
            m_fall = '0;
            if (k % TICK_DIV == 0) begin
                for (int i = 0; i < 5; i++) begin
                    if (sb[i] != m_clean[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == DB_COUNT) begin
                            m_cnt[i] = 0;
                            nv = m_clean;
                            nv[i] = ~nv[i];
                            m_clean = nv;
                            if ((k / TICK_DIV - 1) >= DB_COUNT) begin
                                if (nv[i]) m_rise[i] = 1'b1;
                                else       m_fall[i] = 1'b1;
                            end
                        end
                    end else begin
                        m_cnt[i] = 0;
                    end
                end
                m_ready = ((k / TICK_DIV) >= DB_COUNT);
            end
        end
        #1;
        chk("clean", 32'(Clean), 32'(m_clean));
        chk("rise",  32'(Rise),  32'(m_rise));
        chk("fall",  32'(Fall),  32'(m_fall));
        chk("ready", 32'(Ready), 32'(m_ready));
        chk("rise_fall_overlap", 32'(Rise & Fall), 32'd0);
        if (Rise != 0) begin rise_seen++; rise_val = Rise; end
        if (Fall != 0) begin fall_seen++; fall_val = Fall; end
        $display("t=%0t rst=%b raw=%b clean=%b rise=%b fall=%b ready=%b",
                 $time, Rst, Raw, Clean, Rise, Fall, Ready);
    endtask

    task automatic clear_seen();
        rise_seen = 0;
        fall_seen = 0;
        rise_val  = '0;
        fall_val  = '0;
    endtask

    // Watchdog against a stuck simulation.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] cur;
        logic [4:0] g;
        int wait_n;
        clear_seen();

        // Power-up with Raw[0] held high through reset.
        for (int j = 0; j < 3; j++) step(5'b00001, 1'b0);
        chk("reset_clean", 32'(Clean), 32'd0);
        chk("reset_ready", 32'(Ready), 32'd0);
        chk("reset_rise",  32'(Rise),  32'd0);

        clear_seen();
        for (int j = 1; j <= 12; j++) begin
            step(5'b00001, 1'b1);
            chk("pwr_clean", 32'(Clean), (j == 12) ? 32'd1 : 32'd0);
            chk("pwr_ready", 32'(Ready), (j == 12) ? 32'd1 : 32'd0);
        end
        chk("pwr_rise_count", 32'(rise_seen), 32'd0);

        // Release bit0; the model follows the resulting Fall pulse.
        for (int j = 0; j < 16; j++) step(5'b00000, 1'b1);

        // One-cycle glitch on Raw[1] placed between ticks.
        while (k % TICK_DIV != 1) step(5'b00000, 1'b1);
        clear_seen();
        step(5'b00010, 1'b1);
        for (int j = 0; j < 16; j++) step(5'b00000, 1'b1);
        chk("glitch1_clean", 32'(Clean), 32'd0);
        chk("glitch1_pulses", 32'(rise_seen + fall_seen), 32'd0);

        // Raw[1] high for exactly two ticks; the count must clear.
        clear_seen();
        for (int j = 0; j < 8; j++) step(5'b00010, 1'b1);
        for (int j = 0; j < 16; j++) step(5'b00000, 1'b1);
        chk("glitch2_clean", 32'(Clean), 32'd0);
        chk("glitch2_pulses", 32'(rise_seen + fall_seen), 32'd0);

        // Raw[2] rise and fall.
        clear_seen();
        for (int j = 0; j < 16; j++) step(5'b00100, 1'b1);
        chk("rise2_clean", 32'(Clean), 32'h04);
        chk("rise2_count", 32'(rise_seen), 32'd1);
        chk("rise2_val",   32'(rise_val),  32'h04);
        chk("rise2_fall",  32'(fall_seen), 32'd0);
        clear_seen();
        for (int j = 0; j < 16; j++) step(5'b00000, 1'b1);
        chk("fall2_clean", 32'(Clean), 32'd0);
        chk("fall2_count", 32'(fall_seen), 32'd1);
        chk("fall2_val",   32'(fall_val),  32'h04);
        chk("fall2_rise",  32'(rise_seen), 32'd0);

        // Raw[0] and Raw[4] together.
        clear_seen();
        for (int j = 0; j < 16; j++) step(5'b10001, 1'b1);
        chk("dual_clean", 32'(Clean), 32'h11);
        chk("dual_count", 32'(rise_seen), 32'd1);
        chk("dual_val",   32'(rise_val),  32'h11);

        // Reset in the middle of accumulating on Raw[3].
        wait_n = 0;
        step(5'b11001, 1'b1);
        while (m_cnt[3] != 2 && wait_n < 40) begin
            step(5'b11001, 1'b1);
            wait_n++;
        end
        chk("acc_wait", 32'(m_cnt[3]), 32'd2);
        step(5'b11001, 1'b0);
        chk("midrst_clean", 32'(Clean), 32'd0);
        chk("midrst_ready", 32'(Ready), 32'd0);
        clear_seen();
        for (int j = 1; j <= 12; j++) begin
            step(5'b11001, 1'b1);
            chk("requal_clean", 32'(Clean), (j == 12) ? 32'h19 : 32'd0);
        end
        chk("requal_rise_count", 32'(rise_seen), 32'd0);

        // Randomised phase: slow level changes plus occasional glitches and resets.
        cur = 5'b11001;
        for (int j = 0; j < 900; j++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 23) == 0) cur[b] = ~cur[b];
            end
            g = cur;
            if ($urandom_range(0, 29) == 0) g[$urandom_range(0, 4)] ^= 1'b1;
            step(g, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sensor_input_conditioner.md
# sensor_input_conditioner

Input-side front end of the irrigation controller: brings the raw field switches and sensors (soil humidity Us, drip/sprinkler selectors Bs and Vs, fertilizer request Adub, auxiliary T1) into the Clk domain. It debounces each one on a slow sample tick and delivers clean levels plus one-cycle edge pulses. It sits between the board pins and the top-level control logic (irrigation decision, watering-mode and fertilize/clean state machines); it is the receive counterpart of the display/actuator output path.

## Interface
- TICK_DIV, 50000: Clk cycles per debounce sample tick (1 ms at 50 MHz); legal range ≥1.
- DB_COUNT, 10: consecutive differing samples required to accept a new level; legal range ≥1.
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  reset; synchronous and active-low: state clears on a rising Clk edge while Rst=0.
- Raw  in  5  asynchronous inputs; bit0 Us, bit1 Bs, bit2 Vs, bit3 Adub, bit4 T1.
- Clean  out  5  debounced levels, same bit mapping.
- Rise  out  5  one-cycle pulse per bit when Clean goes 0→1 (only after Ready).
- Fall  out  5  one-cycle pulse per bit when Clean goes 1→0 (only after Ready).
- Ready  out  1  high once the initial qualification window (DB_COUNT ticks) has elapsed.

## Operation
- Reset values: Clean=0, Rise=0, Fall=0, Ready=0; synchronizer flops, prescaler, per-channel counters and ready counter all 0.
- Synchronizer: two flops per bit; the second-stage value is the per-bit Sync value.
- Prescaler: counter 0..TICK_DIV-1, increments every cycle, wraps to 0. Tick is 1 for the single cycle the counter equals TICK_DIV-1. With TICK_DIV=1, Tick is 1 every cycle.
- Per-channel debounce (5 independent copies), counter width clog2(DB_COUNT+1), evaluated only on Tick cycles:
  - If Sync==Clean, the counter is cleared.
  - If Sync!=Clean and counter==DB_COUNT-1, Clean toggles and the counter is cleared.
  - If Sync!=Clean otherwise, the counter increments.
  - Counter holds between ticks. Any matching sample clears the count, so glitches shorter than one agreeing tick never propagate.
- Edge pulses: Rise/Fall are registered in the same edge as the Clean change and last exactly one cycle. They are generated only when Ready is already 1 in the tick cycle. Clean still updates during qualification with no pulse.
- Ready counter: increments on each Tick, saturates at DB_COUNT. Ready=1 from the edge where the counter reaches DB_COUNT. It stays 1 until reset.
- Simultaneous events: channels are fully independent. Multiple Rise/Fall bits may assert in the same cycle. Rise[i] and Fall[i] are never both 1.
- Reset mid-operation: any partially accumulated count is discarded. Ready drops and qualification restarts.

## Timing
- Sync latency: 2 cycles from Raw to Sync.
- Acceptance latency: Clean changes on the edge of the DB_COUNT-th consecutive tick that samples the new Sync value. Worst case from Raw change is 2 + DB_COUNT·TICK_DIV cycles; best case is 2 + (DB_COUNT-1)·TICK_DIV + 1 cycles.
- After Rst release, ticks occur at cycles TICK_DIV, 2·TICK_DIV, …. Ready asserts on cycle DB_COUNT·TICK_DIV.
- Rise/Fall are high for exactly one Clk cycle, coincident with the first cycle of the new Clean value.
- No combinational path from Raw to any output. All outputs are registered.

## Test plan
All scenarios use TICK_DIV=4, DB_COUNT=3, and Raw=0 unless stated.
- Power-up with Raw=5'b00001 held through reset → Clean[0]=1 and Ready=1 both on the 12th edge after Rst release. Rise=0 throughout. All other outputs stay 0.
- After Ready, glitches that are not accepted:
  - Raw[1] high for 1 cycle between ticks → Clean, Rise and Fall unchanged.
  - Raw[1] high for exactly 2 ticks, then low → counter clears, no Clean change.
- After Ready, Raw[2] 0→1 held → Clean[2]=1 on the 3rd tick sampling 1. Rise[2]=5'b00100 for exactly 1 cycle. Fall=0.
- Then Raw[2] 1→0 held → Clean[2]=0 three ticks later. Fall=5'b00100 for 1 cycle.
- Raw[0] and Raw[4] rise in the same cycle → Rise=5'b10001 in a single cycle, Clean=5'b10001.
- Rst=0 for one cycle while Raw[3] has 2 accumulated differing ticks → next edge Clean=0, Ready=0, counters 0. Raw[3] is then accepted only after a full 3-tick window, with Rise suppressed until Ready.
